// File: rtl/fibo_wb_pkg.sv
// fibo_wb_pkg: register map, ID constant and FSM types shared by the Fibonacci Wishbone master
package fibo_wb_pkg;
  localparam logic [7:0] REG_NR    = 8'h00;
  localparam logic [7:0] REG_ID    = 8'h04;
  localparam logic [7:0] REG_IRQ   = 8'h08;
  localparam logic [7:0] REG_ON    = 8'h0C;
  localparam logic [7:0] REG_OFF   = 8'h10;
  localparam logic [7:0] REG_VAL   = 8'h14;
  localparam logic [7:0] REG_WRITE = 8'h18;
  localparam logic [7:0] REG_READ  = 8'h1C;
  localparam logic [7:0] REG_PANIC = 8'h20;
  localparam logic [31:0] FIBO_ID  = 32'h4669626F;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef enum logic {SRC_CMD, SRC_POLL} src_t;
endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: saturating up-counter with clear, flags expiry once it reaches LIMIT
module wb_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(LIMIT);
  // count while enabled, hold at LIMIT, clear has priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + W'(1);
endmodule

// File: rtl/fibonacci_wb_master.sv
// fibonacci_wb_master: command-to-Wishbone bridge with timeout and autonomous VAL polling
module fibonacci_wb_master import fibo_wb_pkg::*; #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          TIMEOUT      = 16,
  parameter int          POLL_PERIOD  = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        poll_en,
  output logic [29:0] poll_value,
  output logic        poll_update,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);
  state_t state;
  src_t   src;
  logic   in_bus, take, bus_exp, poll_exp, poll_done, bus_end;
  assign in_bus    = state == BUS;
  assign take      = cmd_valid && cmd_ready;
  assign bus_end   = in_bus && (wbm_ack_i || bus_exp);
  assign poll_done = bus_end && src == SRC_POLL;
  wb_timeout_ctr #(.LIMIT(TIMEOUT - 1)) u_bus_ctr (
    .clk(wb_clk_i), .rst_n(wb_rst_n_i), .clr(!in_bus), .en(in_bus), .expired(bus_exp)
  );
  wb_timeout_ctr #(.LIMIT(POLL_PERIOD - 1)) u_poll_ctr (
    .clk(wb_clk_i), .rst_n(wb_rst_n_i), .clr(!poll_en || poll_done), .en(poll_en), .expired(poll_exp)
  );
  // transfer sequencer: IDLE arbitrates command over poll, BUS runs one classic cycle, RESP holds the reply
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state       <= IDLE;
      src         <= SRC_CMD;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      poll_value  <= '0;
      poll_update <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      poll_update <= 1'b0;
      case (state)
        IDLE:
          if (take || (poll_en && poll_exp)) begin
            state     <= BUS;
            src       <= take ? SRC_CMD : SRC_POLL;
            cmd_ready <= 1'b0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= 4'hF;
            wbm_we_o  <= take && cmd_we;
            wbm_adr_o <= BASE_ADDRESS | {24'b0, take ? cmd_addr : REG_VAL};
            wbm_dat_o <= take ? cmd_wdata : '0;
          end else cmd_ready <= 1'b1;
        BUS:
          if (bus_end) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            state     <= src == SRC_CMD ? RESP : IDLE;
            cmd_ready <= src == SRC_POLL;
            if (src == SRC_CMD) begin
              rsp_valid <= 1'b1;
              rsp_err   <= !wbm_ack_i;
              rsp_data  <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
            end else if (wbm_ack_i) begin
              poll_value  <= wbm_dat_i[29:0];
              poll_update <= 1'b1;
            end
          end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fibonacci_wb_master.sv
// tb_fibonacci_wb_master: vector table plus corner sequences against a behavioural Fibonacci slave
module tb_fibonacci_wb_master;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int TMO = 16;
  localparam int PP  = 8;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_data;
  logic        poll_en = 1'b0, poll_update;
  logic [29:0] poll_value;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        no_ack = 1'b0;
  logic [31:0] val_reg = 32'h0000_0037, mem_wr;
  int          errors = 0, checks = 0;
  typedef struct {logic [31:0] data; logic err;} exp_t;
  typedef struct {logic we; logic [7:0] addr; logic [31:0] wdata; logic [31:0] exp_data;} vec_t;
  exp_t exp_q[$];
  vec_t tbl[7];

  fibonacci_wb_master #(.BASE_ADDRESS(BASE), .TIMEOUT(TMO), .POLL_PERIOD(PP)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .poll_en(poll_en), .poll_value(poll_value), .poll_update(poll_update),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
    .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );

  always #5 clk = ~clk;

  // peripheral model: one-cycle registered ack, unknown offsets read all-ones
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack <= 1'b0; dat_i <= '0; mem_wr <= '0;
    end else begin
      ack <= 1'b0;
      if (cyc && stb && !ack && !no_ack) begin
        ack <= 1'b1;
        if (we && adr[7:0] == 8'h18) mem_wr <= dat_o;
        dat_i <= adr[7:0] == 8'h04 ? 32'h4669626F : adr[7:0] == 8'h14 ? val_reg :
                 adr[7:0] == 8'h1C ? mem_wr : adr[7:0] == 8'h00 ? 32'h0000_000A : 32'hFFFF_FFFF;
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_wdata = wd;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    exp_q.push_back('{ed, ee});
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("cyc_stb", {cyc, stb}, 2'b11);
    chk("adr", adr, BASE | {24'b0, a});
    chk("sel", sel, 4'hF);
    chk("we", we, w);
    if (w) chk("dat_o", dat_o, wd);
  endtask

  task automatic wait_rsp(output int lat);
    exp_t e;
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("rsp_valid_seen", rsp_valid, 1);
    if (exp_q.size() == 0) begin
      chk("rsp_expected", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_err", rsp_err, e.err);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n;
    logic seen;
    tbl[0] = '{1'b0, 8'h04, 32'h0, 32'h4669626F};
    tbl[1] = '{1'b1, 8'h18, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 8'h1C, 32'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 8'h18, 32'h1234_5678, 32'h0};
    tbl[4] = '{1'b0, 8'h1C, 32'h0, 32'h1234_5678};
    tbl[5] = '{1'b0, 8'h00, 32'h0, 32'h0000_000A};
    tbl[6] = '{1'b0, 8'h20, 32'h0, 32'hFFFF_FFFF};
    repeat (2) @(negedge clk);
    chk("rst_wbm", {cyc, stb, we, sel, adr, dat_o} == '0, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    chk("rst_poll", {poll_update, poll_value}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    foreach (tbl[i]) begin
      issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_data, 1'b0);
      wait_rsp(lat);
      if (i == 0) chk("zero_wait_latency", lat, 2);
      chk("idle_after_rsp", {rsp_valid, cmd_ready, stb}, 3'b010);
    end

    no_ack = 1'b1;
    issue(1'b0, 8'h04, 32'h0, 32'h0, 1'b1);
    n = 1;
    while (stb && n < 100) begin @(negedge clk); if (stb) n++; end
    chk("timeout_stb_cycles", n, TMO);
    chk("timeout_rsp_same_cycle", rsp_valid, 1);
    wait_rsp(lat);
    no_ack = 1'b0;
    issue(1'b0, 8'h04, 32'h0, 32'h4669626F, 1'b0);
    wait_rsp(lat);

    val_reg = 32'h0000_0037;
    poll_en = 1'b1;
    n = 0;
    while (!poll_update && n < 100) begin @(negedge clk); n++; end
    chk("poll_pulse1", poll_update, 1);
    chk("poll_value1", poll_value, 30'd55);
    val_reg = 32'hC000_0059;
    @(negedge clk);
    chk("poll_single_pulse", poll_update, 0);
    n = 1;
    while (!poll_update && n < 100) begin @(negedge clk); n++; end
    chk("poll_interval", n, PP + 2);
    chk("poll_value_trunc", poll_value, 30'h59);
    no_ack = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= poll_update; end
    chk("poll_timeout_no_pulse", seen, 0);
    chk("poll_timeout_value_kept", poll_value, 30'h59);
    poll_en = 1'b0;
    n = 0;
    while (stb && n < 100) begin @(negedge clk); n++; end
    no_ack = 1'b0;
    repeat (2) @(negedge clk);

    val_reg = 32'h0000_0037;
    rsp_ready = 1'b0;
    @(negedge clk);
    poll_en = 1'b1;
    repeat (PP - 1) @(posedge clk);
    issue(1'b0, 8'h04, 32'h0, 32'h4669626F, 1'b0);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= stb | !rsp_valid; end
    chk("collision_stall", seen, 0);
    rsp_ready = 1'b1;
    wait_rsp(lat);
    chk("collision_idle_gap", stb, 0);
    @(negedge clk);
    chk("collision_poll_stb", stb, 1);
    chk("collision_poll_adr", adr, BASE | 32'h14);
    chk("collision_poll_we", we, 0);
    n = 0;
    while (!poll_update && n < 100) begin @(negedge clk); n++; end
    chk("collision_poll_value", poll_value, 30'd55);
    poll_en = 1'b0;
    repeat (2) @(negedge clk);

    no_ack = 1'b1;
    issue(1'b0, 8'h04, 32'h0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc_stb", {cyc, stb}, 2'b00);
    chk("async_rst_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    no_ack = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= rsp_valid | stb; end
    chk("no_rsp_after_rst", seen, 0);
    chk("cmd_ready_after_abort", cmd_ready, 1);
    issue(1'b0, 8'h1C, 32'h0, 32'h0, 1'b0);
    wait_rsp(lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
